// File: rtl/dm_pkg.sv
// dm_pkg: shared op codes, state enum and lane helpers
// for the MEM-stage data-memory unit.
package dm_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    BUSY
  } state_t;

  function automatic logic op_err(
    input logic       we,
    input logic [2:0] op,
    input logic [1:0] a
  );
    logic bad;
    logic mis;
    bad = (op == 3'b011) || (op == 3'b110) ||
          (op == 3'b111) || (we && op[1:0] == 2'b11);
    mis = (op[1:0] == 2'b01 && a[0]) ||
          (op[1:0] == 2'b10 && a != 2'b00);
    return bad || mis;
  endfunction

  function automatic logic [3:0] be_gen(
    input logic [1:0] op,
    input logic [1:0] a
  );
    logic [3:0] be;
    case (op)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_rep(
    input logic [1:0]  op,
    input logic [31:0] wd
  );
    logic [31:0] r;
    case (op)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ld_ext(
    input logic [2:0]  op,
    input logic [1:0]  a,
    input logic [31:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (op)
      OP_B:    r = {{24{b[7]}}, b};
      OP_BU:   r = {24'h0, b};
      OP_H:    r = {{16{h[15]}}, h};
      OP_HU:   r = {16'h0, h};
      OP_W:    r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// dm_ram: word array with byte write enables
// and combinational read.
module dm_ram #(
  parameter int AW    = 11,
  parameter int DEPTH = 2048
) (
  input  logic          clk,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (be[k]) mem_q[waddr][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dm_unit.sv
// dm_unit: MEM-stage data memory with handshake,
// lane steering, load extension and optional clear sweep.
module dm_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int IW    = ADDR_W - 2;
  localparam int DEPTH = 2 ** IW;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     pend_rdata_q, pend_rdata_d;
  logic            pend_err_q, pend_err_d;
  logic [31:0]     hold_rdata_q, hold_rdata_d;
  logic            hold_err_q, hold_err_d;

  logic            accept;
  logic            err;
  logic [31:0]     rd_word;
  logic [IW-1:0]   ram_waddr;
  logic [3:0]      ram_be;
  logic [31:0]     ram_wdata;

  assign rsp_valid = (state_q == BUSY) && (cnt_q == 3'd0);
  assign req_ready = (state_q == IDLE) || rsp_valid;
  assign init_done = (state_q != INIT);
  assign accept    = req_valid && req_ready;
  assign err       = op_err(req_we, req_op, req_addr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? INIT : IDLE;
      cnt_q        <= 3'd0;
      idx_q        <= '0;
      pend_rdata_q <= 32'h0;
      pend_err_q   <= 1'b0;
      hold_rdata_q <= 32'h0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
      hold_rdata_q <= hold_rdata_d;
      hold_err_q   <= hold_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = 3'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else if (accept) cnt_d = 3'(LATENCY - 1);
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_waddr    = req_addr[ADDR_W-1:2];
    ram_be       = 4'b0000;
    ram_wdata    = 32'h0;
    pend_rdata_d = pend_rdata_q;
    pend_err_d   = pend_err_q;
    hold_rdata_d = hold_rdata_q;
    hold_err_d   = hold_err_q;
    if (state_q == INIT) begin
      ram_waddr = idx_q;
      ram_be    = 4'b1111;
    end else if (accept && req_we && !err) begin
      ram_be    = be_gen(req_op[1:0], req_addr[1:0]);
      ram_wdata = wdata_rep(req_op[1:0], req_wdata);
    end
    // load data is sampled at accept; outputs only move on a strobe
    if (accept) begin
      pend_err_d   = err;
      pend_rdata_d = (err || req_we) ? 32'h0 :
                     ld_ext(req_op, req_addr[1:0], rd_word);
    end
    if (rsp_valid) begin
      hold_rdata_d = pend_rdata_q;
      hold_err_d   = pend_err_q;
    end
  end

  assign rsp_rdata = rsp_valid ? pend_rdata_q : hold_rdata_q;
  assign rsp_err   = rsp_valid ? pend_err_q : hold_err_q;

  dm_ram #(
    .AW    (IW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .waddr (ram_waddr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .raddr (req_addr[ADDR_W-1:2]),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_dm_unit.sv
// tb_dm_unit: directed scoreboard bench for dm_unit
// across sweep, lanes, errors, latency and reset cases.
module tb_dm_unit;
  import dm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // main unit: default geometry, clear sweep, latency 1
  logic        rst, req_valid, req_we;
  logic [2:0]  req_op;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, rsp_valid, rsp_err, init_done;
  logic [31:0] rsp_rdata;

  dm_unit #(.ADDR_W(13), .LATENCY(1), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done)
  );

  // latency-3 unit for throughput
  logic        b_rst, b_valid, b_we;
  logic [2:0]  b_op;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic        b_ready, b_rsp_valid, b_rsp_err, b_init_done;
  logic [31:0] b_rsp_rdata;

  dm_unit #(.ADDR_W(8), .LATENCY(3), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .reset(b_rst),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_op(b_op),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .init_done(b_init_done)
  );

  // latency-4 unit without sweep for reset-in-busy
  logic        c_rst, c_valid, c_we;
  logic [2:0]  c_op;
  logic [7:0]  c_addr;
  logic [31:0] c_wdata;
  logic        c_ready, c_rsp_valid, c_rsp_err, c_init_done;
  logic [31:0] c_rsp_rdata;
  int          c_seen = 0;

  dm_unit #(.ADDR_W(8), .LATENCY(4), .CLEAR_ON_RESET(0)) dut_c (
    .clk(clk), .reset(c_rst),
    .req_valid(c_valid), .req_ready(c_ready),
    .req_we(c_we), .req_op(c_op),
    .req_addr(c_addr), .req_wdata(c_wdata),
    .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata),
    .rsp_err(c_rsp_err), .init_done(c_init_done)
  );

  always @(negedge clk) if (c_rsp_valid === 1'b1) c_seen++;

  logic [32:0] sbq [$];
  int          rsp_cyc [$];
  logic [32:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rsp_cyc.push_back(cyc);
      tests++;
      assert (sbq.size() != 0) else begin
        fails++;
        $error("FAIL rsp_unexpected: got %h expected none",
               {rsp_err, rsp_rdata});
      end
      if (sbq.size() != 0) begin
        mon_exp = sbq.pop_front();
        tests++;
        assert ({rsp_err, rsp_rdata} === mon_exp) else begin
          fails++;
          $error("FAIL rsp_data: got %h expected %h",
                 {rsp_err, rsp_rdata}, mon_exp);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] op,
                      input logic [12:0] addr, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    assert (req_ready === 1'b1) else begin
      fails++;
      $error("FAIL send_timeout: ready %b expected 1", req_ready);
    end
    sbq.push_back({ee, er});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    assert (sbq.size() == 0) else begin
      fails++;
      $error("FAIL drain: pending %0d expected 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic measure_sweep(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, 2048);
    chk({tag, "_done"}, 32'(init_done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_op = OP_W; req_addr = '0; req_wdata = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_we = 1'b0;
    b_op = OP_W; b_addr = '0; b_wdata = '0;
    c_rst = 1'b1; c_valid = 1'b0; c_we = 1'b0;
    c_op = OP_W; c_addr = '0; c_wdata = '0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    chk("rst_b_init_done", 32'(b_init_done), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    measure_sweep("sweep1");

    send(1'b1, OP_W, 13'h7FC, 32'hDEADBEEF, 32'h0, 1'b0);
    send(1'b0, OP_W, 13'h7FC, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    measure_sweep("sweep2");
    send(1'b0, OP_W, 13'h7FC, 32'h0, 32'h0, 1'b0);

    send(1'b1, OP_W,  13'h010, 32'h11223344, 32'h0, 1'b0);
    send(1'b0, OP_B,  13'h013, 32'h0, 32'h00000011, 1'b0);
    send(1'b0, OP_B,  13'h010, 32'h0, 32'h00000044, 1'b0);
    send(1'b0, OP_H,  13'h012, 32'h0, 32'h00001122, 1'b0);
    send(1'b0, OP_HU, 13'h010, 32'h0, 32'h00003344, 1'b0);

    send(1'b1, OP_B,  13'h021, 32'h00000080, 32'h0, 1'b0);
    send(1'b0, OP_W,  13'h020, 32'h0, 32'h00008000, 1'b0);
    send(1'b0, OP_B,  13'h021, 32'h0, 32'hFFFFFF80, 1'b0);
    send(1'b0, OP_BU, 13'h021, 32'h0, 32'h00000080, 1'b0);
    send(1'b1, OP_H,  13'h022, 32'h0000BEEF, 32'h0, 1'b0);
    send(1'b0, OP_W,  13'h020, 32'h0, 32'hBEEF8000, 1'b0);
    send(1'b0, OP_H,  13'h022, 32'h0, 32'hFFFFBEEF, 1'b0);
    drain();
    @(posedge clk); #1;
    chk("hold_rdata", rsp_rdata, 32'hFFFFBEEF);
    chk("hold_valid", 32'(rsp_valid), 32'd0);

    send(1'b1, OP_W,   13'h004, 32'h55667788, 32'h0, 1'b0);
    send(1'b1, OP_W,   13'h006, 32'h99999999, 32'h0, 1'b1);
    send(1'b0, OP_W,   13'h004, 32'h0, 32'h55667788, 1'b0);
    send(1'b0, OP_H,   13'h003, 32'h0, 32'h0, 1'b1);
    send(1'b0, 3'b111, 13'h000, 32'h0, 32'h0, 1'b1);
    send(1'b1, 3'b011, 13'h008, 32'hFFFFFFFF, 32'h0, 1'b1);
    send(1'b0, OP_W,   13'h008, 32'h0, 32'h0, 1'b0);
    drain();

    rsp_cyc.delete();
    send(1'b0, OP_W, 13'h010, 32'h0, 32'h11223344, 1'b0);
    send(1'b0, OP_W, 13'h020, 32'h0, 32'hBEEF8000, 1'b0);
    send(1'b0, OP_W, 13'h004, 32'h0, 32'h55667788, 1'b0);
    send(1'b0, OP_W, 13'h7FC, 32'h0, 32'h0, 1'b0);
    drain();
    chk("b2b_count", rsp_cyc.size(), 32'd4);
    d = (rsp_cyc.size() == 4) ? rsp_cyc[3] - rsp_cyc[0] : -1;
    chk("b2b_span", d, 32'd3);

    b_we = 1'b1; b_op = OP_W; b_addr = 8'h00; b_wdata = 32'h0;
    b_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("l3_rsp%0d", k), 32'(b_rsp_valid),
          32'(k % 3 == 2));
      chk($sformatf("l3_rdy%0d", k), 32'(b_ready),
          32'(k % 3 == 2));
    end
    @(posedge clk); #1;
    b_valid = 1'b0;

    c_we = 1'b1; c_op = OP_W; c_addr = 8'h40;
    c_wdata = 32'hCAFEF00D; c_valid = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    c_rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    c_rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rstbusy_no_rsp", c_seen, 32'd0);
    c_we = 1'b0; c_valid = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
    d = 0;
    @(negedge clk);
    while (c_rsp_valid !== 1'b1 && d < 20) begin
      @(negedge clk);
      d++;
    end
    chk("rstbusy_rsp", 32'(c_rsp_valid), 32'd1);
    chk("rstbusy_lat", d, 32'd3);
    chk("rstbusy_data", c_rsp_rdata, 32'hCAFEF00D);
    chk("rstbusy_err", 32'(c_rsp_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
